countdown16: RTL and testbench

Loadable 16-bit countdown timer for the Hack CPU's memory-mapped peripheral space, the decrementing counterpart of the PC's increment path. Software loads a start value, starts the count, and the block decrements once every PRESCALE cycles. It raises a one-cycle `expired` pulse on reaching zero, then either halts or reloads automatically. All decrement arithmetic goes through a dedicated combinational decrementer sub-module.

---
 rtl/hack_pkg.sv | 14 +
 rtl/countdown16_dec16.sv | 54 +++++
 rtl/countdown16.sv | 90 +++++++++
 tb/tb_countdown16.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared definitions for the Hack peripheral blocks: word width and the
// countdown timer state encoding.
package hack_pkg;

   localparam int WORD_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/countdown16_dec16.sv
// Combinational 16-bit decrementer (out = in - 1, wrapping) built as a ripple
// chain of half/full adders that adds 0xFFFF, mirroring the PC incrementer.
module HalfAdder (
   input  logic i_a,
   input  logic i_b,
   output logic o_sum,
   output logic o_carry
);
   assign o_sum   = i_a ^ i_b;
   assign o_carry = i_a & i_b;
endmodule

module FullAdder (
   input  logic i_a,
   input  logic i_b,
   input  logic i_c,
   output logic o_sum,
   output logic o_carry
);
   assign o_sum   = i_a ^ i_b ^ i_c;
   assign o_carry = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module Dec16
   import hack_pkg::*;
(
   input  logic [WORD_W-1:0] in,
   output logic [WORD_W-1:0] out
);
   logic [WORD_W-1:0] w_carry;

   HalfAdder u_ha0 (
      .i_a    (in[0]),
      .i_b    (1'b1),
      .o_sum  (out[0]),
      .o_carry(w_carry[0])
   );

   // Every addend bit is 1; the final carry out is the discarded borrow.
   generate
      for (genvar gi = 1; gi < WORD_W; gi++) begin : g_fa
         FullAdder u_fa (
            .i_a    (in[gi]),
            .i_b    (1'b1),
            .i_c    (w_carry[gi-1]),
            .o_sum  (out[gi]),
            .o_carry(w_carry[gi])
         );
      end
   endgenerate

   logic w_unused_carry;
   assign w_unused_carry = w_carry[WORD_W-1];
endmodule

// File: rtl/countdown16.sv
// Loadable 16-bit countdown timer: decrements every PRESCALE cycles, pulses
// expired on the terminal decrement, then halts in DONE or auto-reloads.
module countdown16
   import hack_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [WORD_W-1:0] in,
   input  logic              start,
   input  logic              stop,
   input  logic              auto_reload,
   output logic [WORD_W-1:0] count,
   output logic              running,
   output logic              done,
   output logic              expired
);
   localparam logic [WORD_W-1:0] P_LAST = WORD_W'(PRESCALE - 1);

   state_t            r_state;
   logic [WORD_W-1:0] r_reload;
   logic [WORD_W-1:0] r_count;
   logic [WORD_W-1:0] r_pre;
   logic              r_expired;
   logic [WORD_W-1:0] w_count_dec;

   Dec16 u_dec (
      .in (r_count),
      .out(w_count_dec)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_reload  <= '0;
         r_count   <= '0;
         r_pre     <= '0;
         r_expired <= 1'b0;
      end else begin
         r_expired <= 1'b0;
         if (load) begin
            r_reload <= in;
            r_count  <= in;
            r_pre    <= '0;
            r_state  <= ST_IDLE;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (start && !stop && r_count != '0) begin
                     r_state <= ST_RUN;
                     r_pre   <= '0;
                  end
               end
               ST_RUN: begin
                  // stop freezes both counters, even on a prescale boundary
                  if (stop) begin
                     r_state <= ST_PAUSE;
                  end else if (r_pre == P_LAST) begin
                     r_pre <= '0;
                     if (r_count > WORD_W'(1)) begin
                        r_count <= w_count_dec;
                     end else if (r_count == WORD_W'(1)) begin
                        r_expired <= 1'b1;
                        if (auto_reload && r_reload != '0) begin
                           r_count <= r_reload;
                        end else begin
                           r_count <= '0;
                           r_state <= ST_DONE;
                        end
                     end
                  end else begin
                     r_pre <= r_pre + WORD_W'(1);
                  end
               end
               ST_PAUSE: begin
                  if (start && !stop) r_state <= ST_RUN;
               end
               default: ;
            endcase
         end
      end
   end

   assign count   = r_count;
   assign running = (r_state == ST_RUN);
   assign done    = (r_state == ST_DONE);
   assign expired = r_expired;
endmodule

// File: tb/tb_countdown16.sv
// Drives a PRESCALE=1 and a PRESCALE=4 timer with shared stimulus and checks
// both against an elapsed-time model, plus directed scenario expectations.
module tb_countdown16;
   logic        clk = 1'b0;
   logic        reset = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0, auto_reload = 1'b0;
   logic [15:0] din = '0;
   logic [15:0] count0, count1;
   logic        running0, running1, done0, done1, expired0, expired1;

   int total = 0;
   int bad = 0;

   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
   int m_mode[2], m_cnt[2], m_rel[2], m_el[2], m_exp[2];
   int pre[2] = '{1, 4};

   always #5 clk = ~clk;

   countdown16 #(.PRESCALE(1)) u0 (
      .clk(clk), .reset(reset), .load(load), .in(din), .start(start), .stop(stop),
      .auto_reload(auto_reload), .count(count0), .running(running0), .done(done0),
      .expired(expired0)
   );

   countdown16 #(.PRESCALE(4)) u1 (
      .clk(clk), .reset(reset), .load(load), .in(din), .start(start), .stop(stop),
      .auto_reload(auto_reload), .count(count1), .running(running1), .done(done1),
      .expired(expired1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Timer as seen from outside: every PRESCALE-th cycle spent running
   // takes one unit off the count.
   task automatic model_step(input int k);
      m_exp[k] = 0;
      if (reset) begin
         m_mode[k] = M_IDLE; m_cnt[k] = 0; m_rel[k] = 0; m_el[k] = 0;
      end else if (load) begin
         m_mode[k] = M_IDLE; m_cnt[k] = din; m_rel[k] = din; m_el[k] = 0;
      end else if (m_mode[k] == M_RUN && stop) begin
         m_mode[k] = M_PAUSE;
      end else if (m_mode[k] == M_RUN) begin
         m_el[k]++;
         if (m_el[k] % pre[k] == 0) begin
            if (m_cnt[k] == 1) begin
               m_exp[k] = 1;
               if (auto_reload && m_rel[k] != 0) m_cnt[k] = m_rel[k];
               else begin
                  m_cnt[k] = 0; m_mode[k] = M_DONE;
               end
            end else begin
               m_cnt[k] = m_cnt[k] - 1;
            end
         end
      end else if (start && !stop) begin
         if (m_mode[k] == M_IDLE && m_cnt[k] != 0) begin
            m_mode[k] = M_RUN; m_el[k] = 0;
         end else if (m_mode[k] == M_PAUSE) begin
            m_mode[k] = M_RUN;
         end
      end
   endtask

   task automatic check_models();
      chk("u0.count", count0, m_cnt[0]);
      chk("u0.running", running0, m_mode[0] == M_RUN);
      chk("u0.done", done0, m_mode[0] == M_DONE);
      chk("u0.expired", expired0, m_exp[0]);
      chk("u1.count", count1, m_cnt[1]);
      chk("u1.running", running1, m_mode[1] == M_RUN);
      chk("u1.done", done1, m_mode[1] == M_DONE);
      chk("u1.expired", expired1, m_exp[1]);
   endtask

   task automatic step(input bit ld, input logic [15:0] v, input bit st, input bit sp,
                       input bit rs);
      reset = rs; load = ld; din = v; start = st; stop = sp;
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      check_models();
      $display("cyc rs=%0b ld=%0b in=%0h st=%0b sp=%0b ar=%0b | c0=%0h r0=%0b d0=%0b e0=%0b | c1=%0h r1=%0b d1=%0b e1=%0b",
               rs, ld, v, st, sp, auto_reload, count0, running0, done0, expired0,
               count1, running1, done1, expired1);
      reset = 0; load = 0; start = 0; stop = 0;
   endtask

   task automatic idle();
      step(0, din, 0, 0, 0);
   endtask

   initial begin
      int n, pulses, drops, runs;
      int seq[6] = '{5, 4, 3, 2, 1, 0};
      logic [15:0] prev;

      // reset state
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      chk("rst.count", count0, 0);
      chk("rst.flags", {running0, done0, expired0}, 0);

      // load 5, start, PRESCALE=1 runs 5..0 on consecutive cycles
      step(1, 16'd5, 0, 0, 0);
      step(0, 16'd5, 1, 0, 0);
      chk("t1.first", count0, 5);
      chk("t1.running", running0, 1);
      pulses = 0;
      for (int i = 1; i < 6; i++) begin
         idle();
         chk("t1.seq", count0, seq[i]);
         if (expired0) pulses++;
      end
      chk("t1.done_at_0", {done0, expired0, running0}, 3'b110);
      for (int i = 0; i < 10; i++) begin
         idle();
         chk("t1.hold", {count0, done0}, {16'd0, 1'b1});
         if (expired0) pulses++;
      end
      chk("t1.pulses", pulses, 1);

      // PRESCALE=4: done 12 cycles after running rises
      step(1, 16'd3, 0, 0, 0);
      step(0, 16'd3, 1, 0, 0);
      chk("t2.running", running1, 1);
      n = 0;
      while (!done1 && n < 100) begin idle(); n++; end
      chk("t2.latency", n, 12);

      // auto reload of 3 for 12 cycles
      auto_reload = 1;
      step(1, 16'd3, 0, 0, 0);
      step(0, 16'd3, 1, 0, 0);
      pulses = 0; drops = 0;
      for (int i = 0; i < 12; i++) begin
         idle();
         if (expired0) begin
            pulses++;
            chk("t3.reload_val", count0, 3);
         end
         if (!running0) drops++;
      end
      chk("t3.pulses", pulses, 4);
      chk("t3.drops", drops, 0);
      auto_reload = 0;

      // pause at 6 with stop and start together
      step(1, 16'd10, 0, 0, 0);
      step(0, 16'd10, 1, 0, 0);
      runs = 0; n = 0;
      while (count0 != 6 && n < 40) begin
         prev = count0; idle(); n++;
         if (count0 != prev) runs++;
      end
      chk("t4.reach6", count0, 6);
      step(0, 16'd10, 1, 1, 0);
      chk("t4.paused", {count0, running0}, {16'd6, 1'b0});
      for (int i = 0; i < 5; i++) begin
         idle();
         chk("t4.frozen", count0, 6);
      end
      step(0, 16'd10, 1, 0, 0);
      chk("t4.resume", {count0, running0}, {16'd6, 1'b1});
      n = 0;
      while (!done0 && n < 40) begin
         prev = count0; idle(); n++;
         if (count0 != prev) runs++;
      end
      chk("t4.run_cycles", runs, 10);

      // start with zero is ignored; then load max value
      step(1, 16'd0, 0, 0, 0);
      step(0, 16'd0, 1, 0, 0);
      chk("t5.zero_start", {running0, done0, expired0}, 0);
      idle();
      chk("t5.zero_idle", running0, 0);
      step(1, 16'hFFFF, 0, 0, 0);
      chk("t5.ffff", {count0, done0}, {16'hFFFF, 1'b0});

      // reset mid-count at 4
      step(1, 16'd8, 0, 0, 0);
      step(0, 16'd8, 1, 0, 0);
      n = 0;
      while (count0 != 4 && n < 40) begin idle(); n++; end
      chk("t6.reach4", count0, 4);
      step(0, 16'd8, 0, 0, 1);
      chk("t6.reset", {count0, running0, done0, expired0}, 19'd0);

      // load 2 mid-count at 4
      step(1, 16'd8, 0, 0, 0);
      step(0, 16'd8, 1, 0, 0);
      n = 0;
      while (count0 != 4 && n < 40) begin idle(); n++; end
      chk("t6.reach4b", count0, 4);
      step(1, 16'd2, 0, 0, 0);
      chk("t6.load2", {count0, running0, done0, expired0}, {16'd2, 3'b000});

      // randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         bit rs, ld, st, sp;
         logic [15:0] v;
         if (i % 40 == 0) auto_reload = 1'($urandom_range(0, 1));
         rs = ($urandom_range(0, 59) == 0);
         ld = ($urandom_range(0, 11) == 0);
         st = ($urandom_range(0, 2) == 0);
         sp = ($urandom_range(0, 9) == 0);
         case ($urandom_range(0, 9))
            0:       v = 16'd0;
            1:       v = 16'($urandom);
            default: v = 16'($urandom_range(1, 7));
         endcase
         step(ld, v, st, sp, rs);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
